// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared radix-2 SDF FFT definitions: sample type, data width and
// bit-reversal helper used by the output reorder buffer.
package R2SdfDefinesPkg;

   localparam int DW = 16;
   localparam int BR_MAXW = 12;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } Cplx;

   typedef enum logic {
      RD_IDLE,
      RD_READ
   } rd_state_e;

   // Reverses the low w bits of v (w <= BR_MAXW); upper bits return 0.
   function automatic logic [BR_MAXW-1:0] bitrev(
      input logic [BR_MAXW-1:0] v,
      input int                 w
   );
      logic [BR_MAXW-1:0] r;
      r = '0;
      for (int i = 0; i < BR_MAXW; i++) begin
         r[i] = v[BR_MAXW-1-i];
      end
      return r >> (BR_MAXW - w);
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Ping/pong sample store: one write port, one registered read port,
// all activity gated by the pipeline clock enable.
module reorder_bank_ram #(
   parameter int AW = 5,
   parameter int W  = 32
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [0:(1<<AW)-1];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[waddr] <= wdata;
         end
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts bit-reversed SDF FFT output into natural frequency order
// using a ping/pong buffer; latency is two enabled cycles.
module fft_bitrev_reorder
   import R2SdfDefinesPkg::*;
#(
   parameter int STG = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  Cplx  in,
   input  logic in_sync,
   output Cplx  out,
   output logic out_valid,
   output logic out_sync,
   output logic frame_err
);

   localparam logic [STG-1:0] LAST = '1;

   logic [STG-1:0] wcnt_q, wcnt_d;
   logic           wsel_q, wsel_d;
   logic           frame_err_q, frame_err_d;
   logic           out_valid_q, out_valid_d;
   logic           out_sync_q, out_sync_d;
   Cplx            out_q, out_d;

   rd_state_e      state_q;
   logic [STG-1:0] rcnt_q;
   logic           rd_v_q;
   logic           rd_last_q;

   logic [STG-1:0] wrev;
   Cplx            rd_data;

   assign wrev = STG'(bitrev(BR_MAXW'(wcnt_q), STG));

   reorder_bank_ram #(
      .AW (STG + 1),
      .W  (2 * DW)
   ) u_ram (
      .clk   (clk),
      .en    (en),
      .we    (1'b1),
      .waddr ({wsel_q, wrev}),
      .wdata (in),
      .raddr ({~wsel_q, rcnt_q}),
      .rdata (rd_data)
   );

   always_comb begin
      wcnt_d      = wcnt_q;
      wsel_d      = wsel_q;
      frame_err_d = frame_err_q;
      out_valid_d = out_valid_q;
      out_sync_d  = out_sync_q;
      out_d       = out_q;
      if (en) begin
         wcnt_d      = in_sync ? '0 : wcnt_q + 1'b1;
         wsel_d      = wsel_q ^ in_sync;
         frame_err_d = in_sync && (wcnt_q != LAST);
         out_valid_d = rd_v_q;
         out_sync_d  = rd_v_q && rd_last_q;
         if (rd_v_q) begin
            out_d = rd_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q      <= '0;
         wsel_q      <= 1'b0;
         frame_err_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_sync_q  <= 1'b0;
         out_q       <= '{re: '0, im: '0};
      end else begin
         wcnt_q      <= wcnt_d;
         wsel_q      <= wsel_d;
         frame_err_q <= frame_err_d;
         out_valid_q <= out_valid_d;
         out_sync_q  <= out_sync_d;
         out_q       <= out_d;
      end
   end

   // A handover always restarts the read, abandoning any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RD_IDLE;
         rcnt_q    <= '0;
         rd_v_q    <= 1'b0;
         rd_last_q <= 1'b0;
      end else if (en) begin
         rd_v_q    <= (state_q == RD_READ);
         rd_last_q <= (state_q == RD_READ) && (rcnt_q == LAST);
         unique case (state_q)
            RD_IDLE: begin
               if (in_sync) begin
                  state_q <= RD_READ;
                  rcnt_q  <= '0;
               end
            end
            RD_READ: begin
               if (in_sync) begin
                  rcnt_q <= '0;
               end else if (rcnt_q == LAST) begin
                  state_q <= RD_IDLE;
                  rcnt_q  <= '0;
               end else begin
                  rcnt_q <= rcnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= RD_IDLE;
            end
         endcase
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_sync  = out_sync_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (STG=4) against a
// frame-level reference model of the bit-reversal reorder.
module tb_fft_bitrev_reorder;
   import R2SdfDefinesPkg::*;

   localparam int STG = 4;
   localparam int N   = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic in_sync = 1'b0;
   Cplx  in_d;
   Cplx  out_d;
   logic out_valid, out_sync, frame_err;

   fft_bitrev_reorder #(.STG(STG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in        (in_d),
      .in_sync   (in_sync),
      .out       (out_d),
      .out_valid (out_valid),
      .out_sync  (out_sync),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   Cplx  nat [2][N];
   Cplx  frame [N];
   int   m_k, m_sel, m_idx;
   bit   m_rd, p1v, p1s;
   Cplx  p1d;
   logic exp_v, exp_s, exp_err;
   Cplx  exp_out;

   function automatic int rev(input int v);
      int r = 0;
      for (int i = 0; i < STG; i++) r = r * 2 + ((v >> i) & 1);
      return r;
   endfunction

   function automatic Cplx mk(input int re, input int im);
      Cplx c;
      c.re = DW'(re);
      c.im = DW'(im);
      return c;
   endfunction

   function automatic Cplx rnd();
      Cplx c;
      c = Cplx'($urandom);
      return c;
   endfunction

   task automatic model_reset();
      m_k = 0; m_sel = 0; m_idx = 0; m_rd = 0;
      p1v = 0; p1s = 0; p1d = '0;
      exp_v = 0; exp_s = 0; exp_err = 0; exp_out = '0;
   endtask

   // Stream index k lands at natural frequency index rev(k).
   task automatic model_step(input Cplx d, input logic s);
      nat[m_sel][rev(m_k)] = d;
      exp_err = s && (m_k != N - 1);
      exp_v = p1v;
      exp_s = p1s;
      if (p1v) exp_out = p1d;
      p1v = m_rd;
      if (m_rd) begin
         p1d = frame[m_idx];
         p1s = (m_idx == N - 1);
      end else begin
         p1s = 0;
      end
      if (s) begin
         for (int i = 0; i < N; i++) frame[i] = nat[m_sel][i];
         m_sel = 1 - m_sel;
         m_k = 0;
         m_rd = 1;
         m_idx = 0;
      end else begin
         m_k = (m_k + 1) % N;
         if (m_rd) begin
            if (m_idx == N - 1) m_rd = 0;
            else m_idx++;
         end
      end
   endtask

   task automatic cyc(input logic e, input Cplx d, input logic s);
      en = e;
      in_d = d;
      in_sync = s;
      @(posedge clk);
      if (e) model_step(d, s);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b0;
      in_d = '0;
      in_sync = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_sync !== 1'b0) begin
         errors++;
         $display("FAIL reset_sync: got %b want 0", out_sync);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %b want 0", frame_err);
      end
      checks++;
      if (out_d !== Cplx'(0)) begin
         errors++;
         $display("FAIL reset_out: got %h want 0", out_d);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_frame();
      Cplx got [$];
      int  sync_at = -1;
      for (int k = 0; k < 3 * N; k++) begin
         if (k < N) cyc(1'b1, mk(k, -k), k == N - 1);
         else cyc(1'b1, '0, 1'b0);
         checks++;
         if ({out_valid, out_sync, frame_err, out_d} !==
             {exp_v, exp_s, exp_err, exp_out}) begin
            errors++;
            $display("FAIL single: got v=%b s=%b e=%b o=%h want v=%b s=%b e=%b o=%h",
                     out_valid, out_sync, frame_err, out_d,
                     exp_v, exp_s, exp_err, exp_out);
         end
         if (out_valid) begin
            if (out_sync) sync_at = got.size();
            got.push_back(out_d);
         end
      end
      checks++;
      if (got.size() != N) begin
         errors++;
         $display("FAIL single_count: got %0d want %0d", got.size(), N);
      end
      for (int i = 0; i < got.size() && i < N; i++) begin
         checks++;
         if (got[i] !== mk(rev(i), -rev(i))) begin
            errors++;
            $display("FAIL single_order[%0d]: got %h want %h",
                     i, got[i], mk(rev(i), -rev(i)));
         end
      end
      checks++;
      if (sync_at != N - 1) begin
         errors++;
         $display("FAIL single_sync_pos: got %0d want %0d", sync_at, N - 1);
      end
   endtask

   task automatic test_back_to_back();
      int run = 0, maxrun = 0, nsync = 0, nerr = 0;
      for (int c = 0; c < 3 * N + 2 * N; c++) begin
         if (c < 3 * N) cyc(1'b1, rnd(), (c % N) == N - 1);
         else cyc(1'b1, '0, 1'b0);
         checks++;
         if ({out_valid, out_sync, frame_err, out_d} !==
             {exp_v, exp_s, exp_err, exp_out}) begin
            errors++;
            $display("FAIL b2b: got v=%b s=%b e=%b o=%h want v=%b s=%b e=%b o=%h",
                     out_valid, out_sync, frame_err, out_d,
                     exp_v, exp_s, exp_err, exp_out);
         end
         run = out_valid ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         if (out_sync) nsync++;
         if (frame_err) nerr++;
      end
      checks++;
      if (maxrun != 3 * N) begin
         errors++;
         $display("FAIL b2b_run: got %0d want %0d", maxrun, 3 * N);
      end
      checks++;
      if (nsync != 3) begin
         errors++;
         $display("FAIL b2b_syncs: got %0d want 3", nsync);
      end
      checks++;
      if (nerr != 0) begin
         errors++;
         $display("FAIL b2b_frame_err: got %0d want 0", nerr);
      end
   endtask

   task automatic test_en_random();
      Cplx  got [$];
      int   k = 0;
      int   guard = 0;
      logic e;
      while (k < 3 * N && guard < 2000) begin
         guard++;
         e = 1'($urandom);
         if (k < N) cyc(e, mk(100 + k, k), e && (k == N - 1));
         else cyc(e, '0, 1'b0);
         if (e) k++;
         checks++;
         if ({out_valid, out_sync, frame_err, out_d} !==
             {exp_v, exp_s, exp_err, exp_out}) begin
            errors++;
            $display("FAIL en_rand: got v=%b s=%b e=%b o=%h want v=%b s=%b e=%b o=%h",
                     out_valid, out_sync, frame_err, out_d,
                     exp_v, exp_s, exp_err, exp_out);
         end
         if (e && out_valid) got.push_back(out_d);
      end
      checks++;
      if (got.size() != N) begin
         errors++;
         $display("FAIL en_rand_count: got %0d want %0d", got.size(), N);
      end
      for (int i = 0; i < got.size() && i < N; i++) begin
         checks++;
         if (got[i] !== mk(100 + rev(i), rev(i))) begin
            errors++;
            $display("FAIL en_rand_order[%0d]: got %h want %h",
                     i, got[i], mk(100 + rev(i), rev(i)));
         end
      end
   endtask

   task automatic test_short_frame();
      int nerr = 0;
      int len [4] = '{N, N, 10, N};
      int restart_seen = 0;
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < len[f]; k++) begin
            cyc(1'b1, rnd(), k == len[f] - 1);
            checks++;
            if ({out_valid, out_sync, frame_err, out_d} !==
                {exp_v, exp_s, exp_err, exp_out}) begin
               errors++;
               $display("FAIL short: got v=%b s=%b e=%b o=%h want v=%b s=%b e=%b o=%h",
                        out_valid, out_sync, frame_err, out_d,
                        exp_v, exp_s, exp_err, exp_out);
            end
            if (frame_err) nerr++;
            if (f == 3 && k == 1 && out_valid && out_d === frame[0]) restart_seen++;
         end
      end
      for (int c = 0; c < 2 * N; c++) begin
         cyc(1'b1, '0, 1'b0);
         checks++;
         if ({out_valid, out_sync, frame_err, out_d} !==
             {exp_v, exp_s, exp_err, exp_out}) begin
            errors++;
            $display("FAIL short_tail: got v=%b s=%b e=%b o=%h want v=%b s=%b e=%b o=%h",
                     out_valid, out_sync, frame_err, out_d,
                     exp_v, exp_s, exp_err, exp_out);
         end
         if (frame_err) nerr++;
      end
      checks++;
      if (nerr != 1) begin
         errors++;
         $display("FAIL short_err_pulses: got %0d want 1", nerr);
      end
      checks++;
      if (restart_seen != 1) begin
         errors++;
         $display("FAIL short_restart: got %0d want 1", restart_seen);
      end
   endtask

   task automatic test_reset_mid();
      int nval_pre = 0, nval_post = 0;
      for (int c = 0; c < N + 7; c++) begin
         cyc(1'b1, rnd(), c == N - 1);
      end
      test_reset();
      for (int c = 0; c < 3 * N; c++) begin
         if (c < N) cyc(1'b1, mk(-c, 7 * c), c == N - 1);
         else cyc(1'b1, '0, 1'b0);
         checks++;
         if ({out_valid, out_sync, frame_err, out_d} !==
             {exp_v, exp_s, exp_err, exp_out}) begin
            errors++;
            $display("FAIL rst_mid: got v=%b s=%b e=%b o=%h want v=%b s=%b e=%b o=%h",
                     out_valid, out_sync, frame_err, out_d,
                     exp_v, exp_s, exp_err, exp_out);
         end
         if (out_valid) begin
            if (c < N) nval_pre++;
            else begin
               checks++;
               if (nval_post < N && out_d !== mk(-rev(nval_post), 7 * rev(nval_post))) begin
                  errors++;
                  $display("FAIL rst_mid_order[%0d]: got %h want %h", nval_post,
                           out_d, mk(-rev(nval_post), 7 * rev(nval_post)));
               end
               nval_post++;
            end
         end
      end
      checks++;
      if (nval_pre != 0) begin
         errors++;
         $display("FAIL rst_mid_early: got %0d want 0", nval_pre);
      end
      checks++;
      if (nval_post != N) begin
         errors++;
         $display("FAIL rst_mid_count: got %0d want %0d", nval_post, N);
      end
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < N; i++) nat[b][i] = '0;
      for (int i = 0; i < N; i++) frame[i] = '0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_en_random();
      test_short_frame();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
